// File: rtl/sort_stream_tx.sv
// sort_stream_tx: captures a 5-word frame from the merge sorter on a load
// strobe and streams it out one word per cycle over valid/ready. The frame
// can be sent forward, reversed, or forward with adjacent duplicates dropped.
// sort_err flags a captured frame that is not ascending.
//
//   state | meaning
//   IDLE  | no frame held, waiting for load
//   SEND  | frame held, presenting words on the stream
module sort_stream_tx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic [WIDTH-1:0] din4,
    input  logic [WIDTH-1:0] din5,
    input  logic [1:0]       mod,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             sort_err
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [WIDTH-1:0] seq    [5];
    logic [WIDTH-1:0] seq_in [5];
    logic [4:0]       keep;
    logic [4:0]       keep_in;
    logic [2:0]       idx;
    logic [2:0]       nxt_idx;
    logic             nxt_last;
    logic             first_last;
    logic             err_in;
    logic             hs;
    logic             load_ok;

    // Reorder the incoming frame into transmit order and mark which entries
    // are actually sent (duplicates of the previous word are skipped in mode 2).
    always_comb begin
        if (mod == 2'd1) begin
            seq_in[0] = din5;
            seq_in[1] = din4;
            seq_in[2] = din3;
            seq_in[3] = din2;
            seq_in[4] = din1;
        end else begin
            seq_in[0] = din1;
            seq_in[1] = din2;
            seq_in[2] = din3;
            seq_in[3] = din4;
            seq_in[4] = din5;
        end
        keep_in = 5'b11111;
        if (mod == 2'd2)
            keep_in = {din5 != din4, din4 != din3, din3 != din2, din2 != din1, 1'b1};
        first_last = ~|keep_in[4:1];
        err_in = (din1 > din2) | (din2 > din3) | (din3 > din4) | (din4 > din5);
    end

    // Lookahead: next kept entry after idx, and whether anything is kept beyond it.
    // The descending scan leaves the lowest qualifying index in nxt_idx.
    always_comb begin
        nxt_idx = idx;
        for (int i = 4; i >= 0; i--) begin
            if (3'(i) > idx && keep[i])
                nxt_idx = 3'(i);
        end
        nxt_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (3'(i) > nxt_idx && keep[i])
                nxt_last = 1'b0;
        end
    end

    assign hs      = out_valid & out_ready;
    assign load_ok = load & ((state == IDLE) | (hs & out_last));

    // Frame capture, word sequencing and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            sort_err  <= 1'b0;
            idx       <= '0;
            keep      <= '0;
        end else if (load_ok) begin
            state     <= SEND;
            seq       <= seq_in;
            keep      <= keep_in;
            idx       <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= seq_in[0];
            out_last  <= first_last;
            sort_err  <= err_in;
        end else if (state == SEND && hs) begin
            if (out_last) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                idx      <= nxt_idx;
                out_data <= seq[nxt_idx];
                out_last <= nxt_last;
            end
        end
    end

endmodule

// File: tb/tb_sort_stream_tx.sv
// Bench for sort_stream_tx: table of frames with expected streams, plus
// hand-written sequences for back-to-back loads and mid-frame reset.
module tb_sort_stream_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] din1, din2, din3, din4, din5;
    logic [1:0]  mod;
    logic        busy, out_valid, out_ready, out_last, sort_err;
    logic [15:0] out_data;

    int total = 0;
    int passed = 0;

    typedef struct packed {
        logic [0:4][15:0] d;
        logic [1:0]       m;
        logic [0:4][15:0] e;
        logic [2:0]       n;
        logic             err;
        logic [15:0]      rdy;
    } vec_t;

    vec_t tab [9];

    sort_stream_tx #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .load(load),
        .din1(din1), .din2(din2), .din3(din3), .din4(din4), .din5(din5),
        .mod(mod), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .sort_err(sort_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mkv(input logic [0:4][15:0] d, input logic [1:0] m,
                                 input logic [0:4][15:0] e, input logic [2:0] n,
                                 input logic err, input logic [15:0] rdy);
        vec_t v;
        v.d = d; v.m = m; v.e = e; v.n = n; v.err = err; v.rdy = rdy;
        return v;
    endfunction

    task automatic set_din(input logic [0:4][15:0] d, input logic [1:0] m);
        din1 = d[0]; din2 = d[1]; din3 = d[2]; din4 = d[3]; din5 = d[4];
        mod  = m;
    endtask

    task automatic run_frame(input vec_t v);
        int n = 0;
        int cyc = 0;
        logic held = 1'b0;
        logic [15:0] hd = '0;
        set_din(v.d, v.m);
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("busy_after_load", {31'd0, busy}, 32'd1);
        chk("valid_after_load", {31'd0, out_valid}, 32'd1);
        chk("sort_err", {31'd0, sort_err}, {31'd0, v.err});
        while (out_valid && cyc < 40) begin
            out_ready = v.rdy[cyc % 16];
            if (held) begin
                chk("hold_data", {16'd0, out_data}, {16'd0, hd});
                chk("hold_last", {31'd0, out_last}, {31'd0, (n == int'(v.n) - 1)});
            end
            if (out_ready) begin
                if (n >= int'(v.n)) chk("extra_word", n, {29'd0, v.n});
                else begin
                    chk("word", {16'd0, out_data}, {16'd0, v.e[n]});
                    chk("last", {31'd0, out_last}, {31'd0, (n == int'(v.n) - 1)});
                end
                n++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                hd = out_data;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 40) chk("timeout", {31'd0, out_valid}, 32'd0);
        chk("handshakes", n, {29'd0, v.n});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("last_end", {31'd0, out_last}, 32'd0);
        chk("data_hold_end", {16'd0, out_data}, {16'd0, v.e[v.n - 3'd1]});
        out_ready = 1'b1;
    endtask

    initial begin
        logic [0:4][15:0] fa, fb;
        logic [0:4][15:0] exp_bb;

        tab[0] = mkv({16'd6, 16'd16, 16'd26, 16'd35, 16'd46}, 2'd0,
                     {16'd6, 16'd16, 16'd26, 16'd35, 16'd46}, 3'd5, 1'b0, 16'hFFFF);
        tab[1] = mkv({16'd6, 16'd16, 16'd26, 16'd35, 16'd46}, 2'd1,
                     {16'd46, 16'd35, 16'd26, 16'd16, 16'd6}, 3'd5, 1'b0, 16'h9999);
        tab[2] = mkv({16'd26, 16'd16, 16'd35, 16'd6, 16'd46}, 2'd0,
                     {16'd26, 16'd16, 16'd35, 16'd6, 16'd46}, 3'd5, 1'b1, 16'hFFFF);
        tab[3] = mkv({16'd5, 16'd5, 16'd9, 16'd9, 16'd9}, 2'd2,
                     {16'd5, 16'd9, 16'd0, 16'd0, 16'd0}, 3'd2, 1'b0, 16'hFFFF);
        tab[4] = mkv({16'd7, 16'd7, 16'd7, 16'd7, 16'd7}, 2'd2,
                     {16'd7, 16'd0, 16'd0, 16'd0, 16'd0}, 3'd1, 1'b0, 16'hFFFF);
        tab[5] = mkv({16'd1, 16'd2, 16'd3, 16'd4, 16'd5}, 2'd3,
                     {16'd1, 16'd2, 16'd3, 16'd4, 16'd5}, 3'd5, 1'b0, 16'hB5AD);
        tab[6] = mkv({16'd3, 16'd3, 16'd1, 16'd1, 16'd3}, 2'd2,
                     {16'd3, 16'd1, 16'd3, 16'd0, 16'd0}, 3'd3, 1'b1, 16'hFFFF);
        tab[7] = mkv({16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF}, 2'd1,
                     {16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0}, 3'd5, 1'b0, 16'hFFFF);
        tab[8] = mkv({16'd1, 16'd2, 16'd2, 16'd3, 16'd3}, 2'd2,
                     {16'd1, 16'd2, 16'd3, 16'd0, 16'd0}, 3'd3, 1'b0, 16'hFFFF);

        rst = 1'b1; load = 1'b0; out_ready = 1'b1;
        set_din({16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_err", {31'd0, sort_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_frame(tab[i]);
            @(posedge clk); #1;
        end

        // Load held high across a frame: mid-frame loads ignored, the one
        // coinciding with the last handshake starts the next frame without a gap.
        fa = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        fb = {16'd10, 16'd20, 16'd30, 16'd25, 16'd50};
        out_ready = 1'b1;
        set_din(fa, 2'd0);
        load = 1'b1;
        @(posedge clk); #1;
        set_din(fb, 2'd1);
        for (int k = 0; k < 10; k++) begin
            exp_bb = (k < 5) ? fa : {16'd50, 16'd25, 16'd30, 16'd20, 16'd10};
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_data", {16'd0, out_data}, {16'd0, exp_bb[k % 5]});
            chk("b2b_last", {31'd0, out_last}, {31'd0, (k == 4 || k == 9)});
            if (k == 4) chk("b2b_err_a", {31'd0, sort_err}, 32'd0);
            if (k == 5) begin
                chk("b2b_err_b", {31'd0, sort_err}, 32'd1);
                load = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("b2b_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Reset after two handshakes aborts the frame; load during rst is dropped.
        set_din({16'd26, 16'd16, 16'd35, 16'd6, 16'd46}, 2'd0);
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("abort_w0", {16'd0, out_data}, 32'd26);
        chk("abort_err", {31'd0, sort_err}, 32'd1);
        @(posedge clk); #1;
        chk("abort_w1", {16'd0, out_data}, 32'd16);
        @(posedge clk); #1;
        chk("abort_w2", {16'd0, out_data}, 32'd35);
        rst = 1'b1; load = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_data", {16'd0, out_data}, 32'd0);
        chk("abort_last", {31'd0, out_last}, 32'd0);
        chk("abort_err_clr", {31'd0, sort_err}, 32'd0);
        @(posedge clk); #1;
        chk("abort_stays_idle", {31'd0, out_valid}, 32'd0);
        run_frame(tab[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
